branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 16, means the number of predictor entries; it SHALL be a power of two from 4 to 64; IDXW = log2(ENTRIES).
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 PCF  in  32  fetch-stage PC.
REQ-005 PredTakenF  out  1  prediction that the instruction at PCF is taken.
REQ-006 PredTargetF  out  32  predicted target; valid only when PredTakenF=1.
REQ-007 StallE  in  1  EX stage is held; when high, no update or counting SHALL occur.
REQ-008 BranchTypeE  in  3  branch type in EX: 0 NOBRANCH, 1 BEQ, 2 BNE, 3 BLT, 4 BLTU, 5 BGE, 6 BGEU; 7 SHALL be treated as NOBRANCH.
REQ-009 BranchE  in  1  actual taken outcome from the branch decision logic.
REQ-010 PCE, BrTargetE  in  32 each  EX PC and resolved branch target.
REQ-011 PredTakenE, PredTargetE  in  1/32  prediction carried down the pipe with the EX instruction.
REQ-012 MispredictE  out  1  EX instruction was mispredicted.
REQ-013 RedirectPCE  out  32  correct next PC; meaningful only when MispredictE=1.
REQ-014 FlushD, FlushE  out  1 each  flush the IF/ID and ID/EX pipeline registers.
REQ-015 BranchCount, MissCount  out  32 each  performance counters (see Configuration).

Function
REQ-016 Storage SHALL be ENTRIES entries of {valid, tag = PC[31:IDXW+2], target[31:0], ctr[1:0]}, indexed by PC[IDXW+1:2].
REQ-017 Lookup SHALL be combinational: hit = valid and tag match at PCF; PredTakenF = hit and ctr[1]; PredTargetF = the entry target.
REQ-018 A resolution SHALL occur when StallE=0 and BranchTypeE is in 1..6.
REQ-019 On resolution, MispredictE SHALL be 1 when BranchE!=PredTakenE, or when BranchE=PredTakenE=1 and PredTargetE!=BrTargetE.
REQ-020 When StallE=0, BranchTypeE is NOBRANCH and PredTakenE=1, MispredictE SHALL be 1, with redirect to PCE+4.
REQ-021 RedirectPCE SHALL be BrTargetE when BranchE=1 on a resolution, and PCE+4 (mod 2^32) otherwise.
REQ-022 FlushD and FlushE SHALL equal MispredictE in the same cycle; MispredictE, FlushD and FlushE SHALL be 0 whenever StallE=1.
REQ-023 Update on resolution, hit at PCE: ctr saturating +1 if taken and -1 if not (3 stays at 3, 0 stays at 0); target <= BrTargetE if taken.
REQ-024 Update on resolution, miss at PCE, taken: allocate (overwrite) the entry with valid=1, tag, target=BrTargetE, ctr=2'b10.
REQ-025 Update on resolution, miss at PCE, not taken: no change.
REQ-026 Update in the REQ-020 case: clear valid of the entry at PCE when it hits.
REQ-027 An update SHALL take effect at the next clk edge; a same-cycle lookup at the same index SHALL see the pre-update contents.

Reset
REQ-028 rst SHALL asynchronously clear every valid bit, set every ctr to 2'b01, and zero targets, tags and counters.
REQ-029 While rst=1: PredTakenF=0, PredTargetF=0, MispredictE=FlushD=FlushE=0, RedirectPCE=0; rst asserted mid-update SHALL discard the update.

Configuration
REQ-030 Macro BRANCH_PERF_CNT_EN, when defined: each resolution increments BranchCount by 1; each cycle with MispredictE=1 increments MissCount by 1; both wrap from 0xFFFFFFFF to 0.
REQ-031 Without BRANCH_PERF_CNT_EN, no counter registers SHALL exist and both ports SHALL be constant 0.

Verification
REQ-032 Reset, PCF=0x100 -> PredTakenF=0; first BEQ at PCE=0x100, BranchE=1, BrTargetE=0x80, PredTakenE=0 -> MispredictE=FlushD=FlushE=1, RedirectPCE=0x80; next cycle PCF=0x100 gives PredTakenF=1, PredTargetF=0x80.
REQ-033 Drive the same branch not-taken 3 times with PredTakenE matching the prediction -> ctr goes 10->01->00->00; only the first resolution mispredicts (RedirectPCE=0x104).
REQ-034 StallE=1 with a mismatched BNE -> MispredictE=0 and entry unchanged; then StallE=0 -> mispredict and update exactly once.
REQ-035 PCE=0x100 and PCE=0x140 (same index for ENTRIES=16), both taken -> the second allocation evicts the first; PCF=0x100 misses.
REQ-036 NOBRANCH at PCE=0x200 with PredTakenE=1 -> MispredictE=1, RedirectPCE=0x204, entry invalidated; with BRANCH_PERF_CNT_EN defined, MissCount+1 and BranchCount unchanged.
REQ-037 rst pulsed mid-sequence between clock edges -> all outputs 0 immediately; previously trained PCs miss afterwards.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit counters and EX-stage resolution.
// Optional perf counters are enabled by defining BRANCH_PERF_CNT_EN.
module branch_predict_unit #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        StallE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAGW-1:0]    tag_q [ENTRIES];
  logic [TAGW-1:0]    tag_d [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [31:0]        tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];

  logic [IDXW-1:0] idx_f, idx_e;
  logic [TAGW-1:0] tag_f, tag_e;
  logic            hit_f, hit_e;
  logic            is_br, res, nobr_mis, mis_raw;
  logic            unused_bits;

  assign unused_bits = ^{PCF[1:0]};

  assign idx_f = PCF[IDXW+1:2];
  assign tag_f = PCF[31:IDXW+2];
  assign idx_e = PCE[IDXW+1:2];
  assign tag_e = PCE[31:IDXW+2];
  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

  assign is_br    = (BranchTypeE >= 3'd1) && (BranchTypeE <= 3'd6);
  assign res      = !StallE && is_br;
  assign nobr_mis = !StallE && !is_br && PredTakenE;
  assign mis_raw  = (res && ((BranchE != PredTakenE) ||
                     (BranchE && PredTakenE && (PredTargetE != BrTargetE))))
                    || nobr_mis;

  assign PredTakenF  = !rst && hit_f && ctr_q[idx_f][1];
  assign PredTargetF = rst ? 32'd0 : tgt_q[idx_f];
  assign MispredictE = !rst && mis_raw;
  assign FlushD      = MispredictE;
  assign FlushE      = MispredictE;
  assign RedirectPCE = rst ? 32'd0 :
                       (res && BranchE) ? BrTargetE : PCE + 32'd4;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (res) begin
      if (hit_e) begin
        if (BranchE) begin
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
          tgt_d[idx_e] = BrTargetE;
        end else if (ctr_q[idx_e] != 2'b00) begin
          ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
        end
      end else if (BranchE) begin
        valid_d[idx_e] = 1'b1;
        tag_d[idx_e]   = tag_e;
        tgt_d[idx_e]   = BrTargetE;
        ctr_d[idx_e]   = 2'b10;
      end
    end else if (nobr_mis && hit_e) begin
      valid_d[idx_e] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  always_comb begin
    bcnt_d = bcnt_q + (res ? 32'd1 : 32'd0);
    mcnt_d = mcnt_q + (MispredictE ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
      mcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      mcnt_q <= mcnt_d;
    end
  end

  assign BranchCount = bcnt_q;
  assign MissCount   = mcnt_q;
`else
  assign BranchCount = 32'd0;
  assign MissCount   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Random plus directed checks of branch_predict_unit against a table-level model.
module tb_branch_predict_unit;
  localparam int N  = 16;
  localparam int IW = 4;

  logic        clk, rst;
  logic [31:0] PCF, PredTargetF, PCE, BrTargetE, PredTargetE;
  logic        PredTakenF, StallE, BranchE, PredTakenE;
  logic [2:0]  BranchTypeE;
  logic        MispredictE, FlushD, FlushE;
  logic [31:0] RedirectPCE, BranchCount, MissCount;

  branch_predict_unit #(.ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .PCF(PCF),
    .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .StallE(StallE), .BranchTypeE(BranchTypeE), .BranchE(BranchE),
    .PCE(PCE), .BrTargetE(BrTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .FlushD(FlushD), .FlushE(FlushE),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference table: entry remembers the full PC that allocated it
  bit          m_valid [N];
  logic [31:0] m_pc    [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  logic [31:0] m_bcnt, m_mcnt;
  logic        o_ptf, o_mis;
  logic [31:0] o_red;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit mhit(input logic [31:0] pc);
    int i = midx(pc);
    return m_valid[i] && ((m_pc[i] >> (IW + 2)) == (pc >> (IW + 2)));
  endfunction

  function automatic bit mpred(input logic [31:0] pc);
    return mhit(pc) && (m_ctr[midx(pc)] >= 2);
  endfunction

  task automatic mreset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_pc[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic cyc(input logic [31:0] pcf, input bit stall,
                     input logic [2:0] bt, input bit br,
                     input logic [31:0] pce, input logic [31:0] tgt,
                     input bit ptk, input logic [31:0] ptgt);
    bit isbr, emis;
    logic [31:0] ered;
    int i;
    PCF = pcf; StallE = stall; BranchTypeE = bt; BranchE = br;
    PCE = pce; BrTargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
    #1;
    isbr = (bt >= 1) && (bt <= 6);
    if (stall) emis = 0;
    else if (isbr) emis = (br != ptk) || (br && ptk && ptgt != tgt);
    else emis = ptk;
    ered = (!stall && isbr && br) ? tgt : pce + 4;
    chk("ptf", PredTakenF, mpred(pcf));
    if (mpred(pcf)) chk("ptgt", PredTargetF, m_tgt[midx(pcf)]);
    chk("mis", MispredictE, emis);
    chk("flushd", FlushD, emis);
    chk("flushe", FlushE, emis);
    if (emis) chk("redir", RedirectPCE, ered);
`ifdef BRANCH_PERF_CNT_EN
    chk("bcnt", BranchCount, m_bcnt);
    chk("mcnt", MissCount, m_mcnt);
`else
    chk("bcnt0", BranchCount, 0);
    chk("mcnt0", MissCount, 0);
`endif
    o_ptf = PredTakenF; o_mis = MispredictE; o_red = RedirectPCE;
    @(posedge clk);
    i = midx(pce);
    if (!stall) begin
      if (isbr) begin
        m_bcnt++;
        if (mhit(pce)) begin
          if (br) begin
            if (m_ctr[i] < 3) m_ctr[i]++;
            m_tgt[i] = tgt;
          end else if (m_ctr[i] > 0) m_ctr[i]--;
        end else if (br) begin
          m_valid[i] = 1; m_pc[i] = pce; m_tgt[i] = tgt; m_ctr[i] = 2;
        end
      end else if (ptk && mhit(pce)) begin
        m_valid[i] = 0;
      end
    end
    if (emis) m_mcnt++;
    #2;
  endtask

  task automatic idle(input logic [31:0] pcf);
    cyc(pcf, 0, 3'd0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] pce, pcf, tgt, ptgt;
    bit ptk, br, st;
    logic [2:0] bt;
    mreset();
    PCF = 0; StallE = 0; BranchTypeE = 0; BranchE = 0; PCE = 0;
    BrTargetE = 0; PredTakenE = 0; PredTargetE = 0;
    rst = 1;
    #12;
    chk("rst_ptf", PredTakenF, 0);
    chk("rst_red", RedirectPCE, 0);
    rst = 0;
    #1;

    // first-time taken branch allocates
    cyc(32'h100, 0, 3'd1, 1, 32'h100, 32'h80, 0, 32'h0);
    chk("r32_ptf0", o_ptf, 0);
    chk("r32_mis", o_mis, 1);
    chk("r32_red", o_red, 32'h80);
    idle(32'h100);
    chk("r32_ptf1", o_ptf, 1);

    // train down: 10 -> 01 -> 00 -> 00
    cyc(32'h100, 0, 3'd1, 0, 32'h100, 32'h80, 1, 32'h80);
    chk("r33_mis1", o_mis, 1);
    chk("r33_red", o_red, 32'h104);
    cyc(32'h100, 0, 3'd1, 0, 32'h100, 32'h80, 0, 32'h0);
    chk("r33_mis2", o_mis, 0);
    cyc(32'h100, 0, 3'd1, 0, 32'h100, 32'h80, 0, 32'h0);
    cyc(32'h100, 0, 3'd1, 1, 32'h100, 32'h80, 0, 32'h0);
    idle(32'h100);
    chk("r33_sat0", o_ptf, 0);

    // stalled mismatch, then released
    cyc(32'h100, 1, 3'd2, 1, 32'h100, 32'h90, 0, 32'h0);
    chk("r34_stall", o_mis, 0);
    cyc(32'h100, 1, 3'd2, 1, 32'h100, 32'h90, 0, 32'h0);
    cyc(32'h100, 0, 3'd2, 1, 32'h100, 32'h90, 0, 32'h0);
    chk("r34_go", o_mis, 1);
    idle(32'h100);
    chk("r34_ptf", o_ptf, 1);

    // aliasing eviction
    cyc(32'h100, 0, 3'd1, 1, 32'h140, 32'h300, 0, 32'h0);
    idle(32'h100);
    chk("r35_evict", o_ptf, 0);

    // NOBRANCH with stale prediction invalidates
    cyc(32'h0, 0, 3'd1, 1, 32'h200, 32'h20, 0, 32'h0);
    cyc(32'h200, 0, 3'd0, 0, 32'h200, 32'h0, 1, 32'h20);
    chk("r36_mis", o_mis, 1);
    chk("r36_red", o_red, 32'h204);
    idle(32'h200);
    chk("r36_inv", o_ptf, 0);

    // random traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 600; n++) begin
      pce  = 32'h100 + ($urandom_range(0, 63) << 2);
      pcf  = 32'h100 + ($urandom_range(0, 63) << 2);
      tgt  = ($urandom_range(0, 7) << 4) + 32'h1000;
      bt   = 3'($urandom_range(0, 7));
      br   = $urandom_range(0, 1) == 1;
      st   = $urandom_range(0, 4) == 0;
      if ($urandom_range(0, 3) != 0) begin
        ptk  = mpred(pce);
        ptgt = m_tgt[midx(pce)];
      end else begin
        ptk  = $urandom_range(0, 1) == 1;
        ptgt = tgt;
      end
      cyc(pcf, st, bt, br, pce, tgt, ptk, ptgt);
    end

    // asynchronous reset between edges
    cyc(32'h180, 0, 3'd3, 1, 32'h180, 32'h40, 0, 32'h0);
    PCF = 32'h180; BranchTypeE = 3'd0; PredTakenE = 1; PCE = 32'h500;
    #2;
    rst = 1;
    #1;
    chk("r37_ptf", PredTakenF, 0);
    chk("r37_ptgt", PredTargetF, 0);
    chk("r37_mis", MispredictE, 0);
    chk("r37_fd", FlushD, 0);
    chk("r37_red", RedirectPCE, 0);
    mreset();
    @(posedge clk);
    #3;
    rst = 0;
    #1;
    idle(32'h180);
    chk("r37_miss", o_ptf, 0);
    idle(32'h100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
